id_ex_skid_reg: RTL and testbench

//  Parametrised ID->EX pipeline register with valid/ready handshake and a 2-entry skid buffer.

---
 rtl/id_ex_skid_reg.sv | 184 ++++++++++++++++++
 tb/tb_id_ex_skid_reg.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid_reg.sv
// ID->EX pipeline register with valid/ready handshake and a 2-entry skid buffer.
// Optional EX back-pressure counter enabled by defining STALL_CNT_EN.
module id_ex_skid_reg #(
    parameter int sizeVal = 32,
    parameter int sizeAd  = 5,
    parameter int CTRL_W  = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Flush,

    input  logic               ValidD,
    output logic               ReadyD,
    input  logic [CTRL_W-1:0]  CtrlD,
    input  logic [sizeVal-1:0] RFRD1D,
    input  logic [sizeVal-1:0] RFRD2D,
    input  logic [sizeAd-1:0]  RsD,
    input  logic [sizeAd-1:0]  RtD,
    input  logic [sizeAd-1:0]  RdD,
    input  logic [sizeVal-1:0] SImmD,

    output logic               ValidE,
    input  logic               ReadyE,
    output logic [CTRL_W-1:0]  CtrlE,
    output logic [sizeVal-1:0] RFRD1E,
    output logic [sizeVal-1:0] RFRD2E,
    output logic [sizeVal-1:0] SImmE,
    output logic [sizeAd-1:0]  RsE,
    output logic [sizeAd-1:0]  RtE,
    output logic [sizeAd-1:0]  RdE,
    output logic [31:0]        StallCnt
);

    typedef struct packed {
        logic [CTRL_W-1:0]  ctrl;
        logic [sizeVal-1:0] rd1;
        logic [sizeVal-1:0] rd2;
        logic [sizeVal-1:0] simm;
        logic [sizeAd-1:0]  rs;
        logic [sizeAd-1:0]  rt;
        logic [sizeAd-1:0]  rd;
    } entry_t;

    // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;

    entry_t main_q;
    entry_t skid_q;
    entry_t d_entry;

    logic main_valid;
    logic skid_valid;
    logic xfer_in;
    logic xfer_out;
    logic load_main;
    logic load_skid;
    logic main_from_skid;

    assign main_valid = state_q[1];
    assign skid_valid = state_q[0];

    // ReadyD depends only on registered state and rst, never on ReadyE.
    assign ReadyD   = ~skid_valid & ~rst;
    assign xfer_in  = ValidD & ReadyD;
    assign xfer_out = main_valid & ReadyE;

    assign d_entry = '{
        ctrl: CtrlD,
        rd1:  RFRD1D,
        rd2:  RFRD2D,
        simm: SImmD,
        rs:   RsD,
        rt:   RtD,
        rd:   RdD
    };

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;

        unique case (state_q)
            EMPTY: begin
                if (xfer_in) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (xfer_in && xfer_out) begin
                    load_main = 1'b1;
                end else if (xfer_in) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (xfer_out) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (xfer_out) begin
                    state_d        = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush kills held entries and drops any same-cycle input.
        if (Flush) begin
            state_d        = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the entry registers are explicitly cleared on reset so every *E
    // output reads 0 after reset, not just ValidE.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= d_entry;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= d_entry;
            end
        end
    end

    // Only control is gated; data/addresses keep their last value when idle.
    assign ValidE = main_valid;
    assign CtrlE  = main_valid ? main_q.ctrl : '0;
    assign RFRD1E = main_q.rd1;
    assign RFRD2E = main_q.rd2;
    assign SImmE  = main_q.simm;
    assign RsE    = main_q.rs;
    assign RtE    = main_q.rt;
    assign RdE    = main_q.rd;

`ifdef STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating; Flush suppresses counting but never clears the total.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (main_valid && !ReadyE && !Flush && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign StallCnt = stall_q;
`else
    assign StallCnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Self-checking bench for id_ex_skid_reg: directed scenarios plus random traffic
// against a queue-based model of an order-preserving 2-deep FIFO.
module tb_id_ex_skid_reg;

    localparam int EW = 120;

    logic         clk = 1'b0;
    logic         rst;
    logic         Flush;
    logic         ValidD;
    logic         ReadyD;
    logic [8:0]   CtrlD;
    logic [31:0]  RFRD1D, RFRD2D, SImmD;
    logic [4:0]   RsD, RtD, RdD;
    logic         ValidE;
    logic         ReadyE;
    logic [8:0]   CtrlE;
    logic [31:0]  RFRD1E, RFRD2E, SImmE;
    logic [4:0]   RsE, RtE, RdE;
    logic [31:0]  StallCnt;

    logic [EW-1:0] d_bus;
    logic [EW-1:0] e_bus;

    assign {CtrlD, RFRD1D, RFRD2D, SImmD, RsD, RtD, RdD} = d_bus;
    assign e_bus = {CtrlE, RFRD1E, RFRD2E, SImmE, RsE, RtE, RdE};

    id_ex_skid_reg dut (
        .clk      (clk),
        .rst      (rst),
        .Flush    (Flush),
        .ValidD   (ValidD),
        .ReadyD   (ReadyD),
        .CtrlD    (CtrlD),
        .RFRD1D   (RFRD1D),
        .RFRD2D   (RFRD2D),
        .RsD      (RsD),
        .RtD      (RtD),
        .RdD      (RdD),
        .SImmD    (SImmD),
        .ValidE   (ValidE),
        .ReadyE   (ReadyE),
        .CtrlE    (CtrlE),
        .RFRD1E   (RFRD1E),
        .RFRD2E   (RFRD2E),
        .SImmE    (SImmE),
        .RsE      (RsE),
        .RtE      (RtE),
        .RdE      (RdE),
        .StallCnt (StallCnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of accepted entries (head is what EX sees).
    logic [EW-1:0] mq[$];
    logic [EW-1:0] last = '0;
    logic [31:0]   stall = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] rand_entry(input logic [31:0] simm, input logic [8:0] ctrl);
        return {ctrl, 32'($urandom), 32'($urandom), simm,
                5'($urandom), 5'($urandom), 5'($urandom)};
    endfunction

    // One clock: check ReadyD before the edge, advance the model, check outputs after.
    task automatic step();
        bit rdy, in_x, out_x;
        logic [EW-1:0] exp_e;
        logic [31:0]   exp_cnt;
        @(negedge clk);
        rdy = (mq.size() < 2) && !rst;
        check("ready_d", ReadyD, rdy);
        @(posedge clk);
        in_x  = ValidD && rdy;
        out_x = (mq.size() > 0) && ReadyE;
        if (rst) begin
            mq.delete();
            last  = '0;
            stall = 0;
        end else begin
            if (mq.size() > 0 && !ReadyE && !Flush && stall != 32'hFFFF_FFFF) stall++;
            if (Flush) begin
                mq.delete();
            end else begin
                if (out_x) void'(mq.pop_front());
                if (in_x) mq.push_back(d_bus);
            end
            if (mq.size() > 0) last = mq[0];
        end
        #1;
        exp_e = last;
        if (mq.size() == 0) exp_e[EW-1 -: 9] = '0;
`ifdef STALL_CNT_EN
        exp_cnt = stall;
`else
        exp_cnt = 32'd0;
`endif
        check("valid_e", ValidE, mq.size() > 0);
        check("e_bus", e_bus, exp_e);
        check("stall_cnt", StallCnt, exp_cnt);
    endtask

    initial begin
        rst    = 1'b1;
        Flush  = 1'b0;
        ValidD = 1'b1;
        ReadyE = 1'b0;
        d_bus  = rand_entry(32'h1234, 9'h1FF);

        // Reset held 2 cycles with a valid input offered
        step();
        step();
        check("rst_e_bus_zero", e_bus, '0);
        check("rst_valid_e", ValidE, 1'b0);
        check("rst_ready_d_low", ReadyD, 1'b0);
        rst    = 1'b0;
        ValidD = 1'b0;
        #1;
        check("post_rst_ready_d", ReadyD, 1'b1);

        // Streaming at full throughput
        ReadyE = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            ValidD = 1'b1;
            d_bus  = rand_entry(32'(i), 9'($urandom));
            step();
            check("stream_simm", SImmE, 32'(i));
            check("stream_ready_d", ReadyD, 1'b1);
        end
        ValidD = 1'b0;
        step();

        // Stall with A, B; C offered throughout
        ReadyE = 1'b0;
        ValidD = 1'b1;
        d_bus  = rand_entry(32'hA, 9'h0A);
        step();
        check("stall_a", SImmE, 32'hA);
        d_bus = rand_entry(32'hB, 9'h0B);
        step();
        check("stall_hold_a", SImmE, 32'hA);
        check("stall_full_ready_d", ReadyD, 1'b0);
        d_bus = rand_entry(32'hC, 9'h0C);
        step();
        step();
        check("stall_still_a", SImmE, 32'hA);
        ReadyE = 1'b1;
        step();
        check("release_b", SImmE, 32'hB);
        step();
        check("release_c", SImmE, 32'hC);
        ValidD = 1'b0;
        step();
        check("drained_valid_e", ValidE, 1'b0);
        check("drained_ctrl_e", CtrlE, 9'h0);

        // Flush while FULL with an all-ones control input
        ReadyE = 1'b0;
        ValidD = 1'b1;
        d_bus  = rand_entry(32'h11, 9'h011);
        step();
        d_bus = rand_entry(32'h22, 9'h022);
        step();
        Flush = 1'b1;
        d_bus = rand_entry(32'h33, 9'h1FF);
        step();
        check("flush_valid_e", ValidE, 1'b0);
        check("flush_ctrl_e", CtrlE, 9'h0);
        check("flush_ready_d", ReadyD, 1'b1);
        Flush  = 1'b0;
        ValidD = 1'b0;
        step();
        check("flush_not_captured", ValidE, 1'b0);

        // rst and Flush together while FULL
        ValidD = 1'b1;
        d_bus  = rand_entry(32'h44, 9'h044);
        step();
        d_bus = rand_entry(32'h55, 9'h055);
        step();
        rst   = 1'b1;
        Flush = 1'b1;
        step();
        check("rst_flush_e_bus", e_bus, '0);
        check("rst_flush_cnt", StallCnt, 32'd0);
        rst    = 1'b0;
        Flush  = 1'b0;
        ValidD = 1'b0;
        step();
        check("rst_flush_empty", ValidE, 1'b0);

        // Five stalled cycles, then Flush keeps the count
        ReadyE = 1'b0;
        ValidD = 1'b1;
        d_bus  = rand_entry(32'h66, 9'h066);
        step();
        ValidD = 1'b0;
        for (int i = 0; i < 5; i++) step();
`ifdef STALL_CNT_EN
        check("stall_cnt_5", StallCnt, 32'd5);
`else
        check("stall_cnt_off", StallCnt, 32'd0);
`endif
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        step();
`ifdef STALL_CNT_EN
        check("stall_cnt_after_flush", StallCnt, 32'd5);
`else
        check("stall_cnt_off_flush", StallCnt, 32'd0);
`endif

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            ValidD = ($urandom % 4) != 0;
            ReadyE = ($urandom % 3) != 0;
            Flush  = ($urandom % 20) == 0;
            rst    = ($urandom % 60) == 0;
            d_bus  = rand_entry($urandom, 9'($urandom));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
